// File: rtl/mips_mem_bus_ctrl.sv
// MIPS32 data-memory bus controller: bank decode, byte-lane steering, load extension, ready-handshake stall.
// Optional build macro MEM_BUS_TIMEOUT_EN adds an ACCESS wait timeout with a sticky bus_err.
module mips_mem_bus_ctrl #(
    parameter int          NUM_BANKS = 3,
    parameter int          BANK_AW   = 13,
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_zext,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    stall,
    output logic [31:0]             rdata,
    output logic                    done,
    output logic                    inv_addr,
    output logic                    bus_err,
    output logic [NUM_BANKS-1:0]    bank_en,
    output logic [3:0]              bank_we,
    output logic [BANK_AW-3:0]      bank_addr,
    output logic [31:0]             bank_wdata,
    input  logic [32*NUM_BANKS-1:0] bank_rdata,
    input  logic [NUM_BANKS-1:0]    bank_ready
);
    localparam int          SEL_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] NUM_BANKS_U = 32'(NUM_BANKS);
    localparam logic [1:0]  SZ_HALF     = 2'd1;
    localparam logic [1:0]  SZ_BYTE     = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, stateNext;

    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extendLoad(input logic [1:0] size, input logic [1:0] lane,
                                               input logic zext, input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: if (zext) ext = {24'h0, b}; else ext = b;
            SZ_HALF: if (zext) ext = {16'h0, h}; else ext = h;
            default: ext = word;
        endcase
        return ext;
    endfunction

    // Address decode on the raw request
    logic [31:0] offset;
    logic [31:0] bankIdx;
    logic        misaligned;
    logic        reqOk;

    always_comb begin
        offset  = req_addr - BASE_ADDR;
        bankIdx = offset >> BANK_AW;
        case (req_size)
            SZ_HALF: misaligned = req_addr[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = |req_addr[1:0];
        endcase
        inv_addr = req_valid & ((req_addr < BASE_ADDR) | (bankIdx >= NUM_BANKS_U) | misaligned);
    end

    assign reqOk = req_valid & ~inv_addr;

    // Request captured on IDLE->ACCESS; inputs are ignored until the access completes
    logic [SEL_W-1:0]   sel_p1;
    logic [BANK_AW-1:0] off_p1;
    logic [1:0]         size_p1;
    logic               zext_p1;
    logic               write_p1;
    logic [31:0]        wdata_p1;

    always_ff @(posedge clk) begin
        if (state == IDLE && reqOk) begin
            sel_p1   <= bankIdx[SEL_W-1:0];
            off_p1   <= offset[BANK_AW-1:0];
            size_p1  <= req_size;
            zext_p1  <= req_zext;
            write_p1 <= req_write;
            wdata_p1 <= req_wdata;
        end
    end

    logic [31:0] selData;
    logic        selReady;
    logic        accessTimeout;

    always_comb begin
        selData  = '0;
        selReady = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel_p1 == SEL_W'(i)) begin
                selData  = bank_rdata[32*i +: 32];
                selReady = bank_ready[i];
            end
        end
    end

    always_comb begin
        bank_en = '0;
        bank_we = '0;
        if (state == ACCESS) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_en[i] = (sel_p1 == SEL_W'(i));
            end
            if (write_p1) bank_we = laneMask(size_p1, off_p1[1:0]);
        end
    end

    assign bank_addr  = off_p1[BANK_AW-1:2];
    assign bank_wdata = replicate(size_p1, wdata_p1);
    assign done       = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = reqOk;
                if (reqOk) stateNext = ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (selReady || accessTimeout) stateNext = RESP;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Response stage: load data latched on the completing edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == ACCESS) begin
            if (selReady)           rdata <= extendLoad(size_p1, off_p1[1:0], zext_p1, selData);
            else if (accessTimeout) rdata <= '0;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] waitCnt;
    logic             busErrReg;

    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) waitCnt <= '0;
        else                        waitCnt <= waitCnt + 1'b1;
    end

    assign accessTimeout = (state == ACCESS) && !selReady && (waitCnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst)                busErrReg <= 1'b0;
        else if (accessTimeout) busErrReg <= 1'b1;
    end

    assign bus_err = busErrReg;
`else
    assign accessTimeout = 1'b0;
    assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_bus_ctrl.sv
// Self-checking bench for mips_mem_bus_ctrl: vector table, randomized traffic against an
// arithmetic reference model, and hand-written wait/timeout/reset sequences.
module tb_mips_mem_bus_ctrl;
    localparam int          NB   = 3;
    localparam int          AW   = 13;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write, req_zext;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          stall, done, inv_addr, bus_err;
    logic [31:0]   rdata;
    logic [NB-1:0] bank_en;
    logic [3:0]    bank_we;
    logic [AW-3:0] bank_addr;
    logic [31:0]   bank_wdata;
    logic [32*NB-1:0] bank_rdata;
    logic [NB-1:0] bank_ready;

    int total = 0;
    int bad   = 0;

    mips_mem_bus_ctrl #(.NUM_BANKS(NB), .BANK_AW(AW), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_zext(req_zext), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rdata(rdata), .done(done), .inv_addr(inv_addr), .bus_err(bus_err), .bank_en(bank_en),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_ready(bank_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          delay;
        logic        expInv;
        logic [2:0]  expEn;
        logic [10:0] expAddr;
        logic [3:0]  expWe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic w, input logic [1:0] sz, input logic z,
                                   input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                   input int dly, input logic inv, input logic [2:0] en,
                                   input logic [10:0] wa, input logic [3:0] we,
                                   input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v.write = w; v.size = sz; v.zext = z; v.addr = a; v.wdata = wd; v.rd = rd; v.delay = dly;
        v.expInv = inv; v.expEn = en; v.expAddr = wa; v.expWe = we; v.expWdata = ewd; v.expRdata = erd;
        return v;
    endfunction

    // Reference model: byte arithmetic on the address map, no knowledge of the controller internals
    function automatic vec_t model(input logic w, input logic [1:0] sz, input logic z,
                                   input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                   input int dly);
        vec_t v;
        longint off, nb, pos, val, full, rep;
        v = mkVec(w, sz, z, a, wd, rd, dly, 1'b0, '0, '0, '0, '0, '0);
        nb  = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
        off = longint'(a) - longint'(BASE);
        v.expInv = (off < 0) || (off / 8192 >= NB) || (longint'(a) % nb != 0);
        if (!v.expInv) begin
            pos  = longint'(a) % 4;
            full = longint'(1) << (8 * nb);
            rep  = (nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'h1;
            v.expEn    = 3'(longint'(1) << (off / 8192));
            v.expAddr  = 11'((off % 8192) / 4);
            if (w) v.expWe = 4'(((longint'(1) << nb) - 1) << pos);
            v.expWdata = 32'((longint'(wd) % full) * rep);
            val = (longint'(rd) >> (8 * pos)) % full;
            if (!z && nb < 4 && val >= full / 2) val -= full;
            v.expRdata = 32'(val);
        end
        return v;
    endfunction

    task automatic runVec(input vec_t v, input string nm);
        logic [NB-1:0] selMask;
        int k, stalls;
        logic finished;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_size = v.size; req_zext = v.zext;
        req_addr = v.addr; req_wdata = v.wdata; bank_ready = '0;
        for (int i = 0; i < NB; i++) bank_rdata[32*i +: 32] = (v.expEn[i]) ? v.rd : $urandom;
        #1;
        chk({nm, ".inv"}, 32'(inv_addr), 32'(v.expInv));
        if (v.expInv) begin
            chk({nm, ".invStall"}, 32'(stall), 32'd0);
            chk({nm, ".invEn"}, 32'(bank_en), 32'd0);
            @(posedge clk); #1;
            chk({nm, ".invEn2"}, 32'(bank_en), 32'd0);
            chk({nm, ".invDone"}, 32'(done), 32'd0);
            req_valid = 1'b0;
            return;
        end
        chk({nm, ".idleStall"}, 32'(stall), 32'd1);
        selMask = v.expEn;
        stalls = 1; k = 0; finished = 1'b0;
        while (!finished && k < v.delay + 6) begin
            @(posedge clk); #1;
            if (done) begin
                if (!v.write) chk({nm, ".rdata"}, rdata, v.expRdata);
                chk({nm, ".respStall"}, 32'(stall), 32'd0);
                chk({nm, ".respEn"}, 32'(bank_en), 32'd0);
                req_valid = 1'b0; bank_ready = '0; finished = 1'b1;
            end else begin
                if (stall) stalls++;
                chk({nm, ".en"}, 32'(bank_en), 32'(v.expEn));
                chk({nm, ".addr"}, 32'(bank_addr), 32'(v.expAddr));
                chk({nm, ".we"}, 32'(bank_we), 32'(v.expWe));
                if (v.write) chk({nm, ".wdata"}, bank_wdata, v.expWdata);
                bank_ready = ~selMask | ((k == v.delay) ? selMask : '0);
                if (k > 0) begin
                    req_addr = $urandom; req_wdata = $urandom;
                    req_size = 2'($urandom); req_zext = 1'($urandom);
                end
                k++;
            end
        end
        chk({nm, ".finished"}, 32'(finished), 32'd1);
        chk({nm, ".stallCycles"}, 32'(stalls), 32'(v.delay + 2));
        @(posedge clk); #1;
        chk({nm, ".doneOnce"}, 32'(done), 32'd0);
        chk({nm, ".idleAfter"}, 32'(stall), 32'd0);
        req_valid = 1'b0; bank_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t rv;
        int r, bank;
        logic [31:0] a;
        logic [1:0] sz;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_zext = 1'b0;
        req_addr = '0; req_wdata = '0; bank_rdata = '0; bank_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.en", 32'(bank_en), 32'd0);
        chk("rst.we", 32'(bank_we), 32'd0);
        chk("rst.busErr", 32'(bus_err), 32'd0);
        chk("rst.inv", 32'(inv_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(mkVec(1, 0, 0, 32'h10010004, 32'hDEADBEEF, 0, 0, 0, 3'b001, 11'd1, 4'hF, 32'hDEADBEEF, 0));
        tbl.push_back(mkVec(0, 2, 0, 32'h10010003, 0, 32'h80FF0000, 0, 0, 3'b001, 11'd0, 4'h0, 0, 32'hFFFFFF80));
        tbl.push_back(mkVec(0, 2, 1, 32'h10010003, 0, 32'h80FF0000, 1, 0, 3'b001, 11'd0, 4'h0, 0, 32'h00000080));
        tbl.push_back(mkVec(1, 1, 0, 32'h10012002, 32'hABCD1234, 0, 0, 0, 3'b010, 11'd0, 4'b1100, 32'h12341234, 0));
        tbl.push_back(mkVec(0, 1, 0, 32'h10014006, 0, 32'h80011234, 5, 0, 3'b100, 11'd1, 4'h0, 0, 32'hFFFF8001));
        tbl.push_back(mkVec(0, 0, 0, 32'h10011FFC, 0, 32'h01234567, 2, 0, 3'b001, 11'h7FF, 4'h0, 0, 32'h01234567));
        tbl.push_back(mkVec(1, 2, 0, 32'h10014001, 32'h000000AB, 0, 0, 0, 3'b100, 11'd0, 4'b0010, 32'hABABABAB, 0));
        tbl.push_back(mkVec(0, 3, 1, 32'h10012008, 0, 32'h89ABCDEF, 1, 0, 3'b010, 11'd2, 4'h0, 0, 32'h89ABCDEF));
        tbl.push_back(mkVec(0, 1, 1, 32'h1001000E, 0, 32'hBEEF0000, 0, 0, 3'b001, 11'd3, 4'h0, 0, 32'h0000BEEF));
        tbl.push_back(mkVec(1, 0, 0, 32'h10016000, 32'h11111111, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0, 32'h1000FFFC, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0, 32'h10010002, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, 0, 32'h10010001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(0, 2, 0, 32'h10016000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], $sformatf("tbl%0d", i));

        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            bank = (r < 8) ? $urandom_range(0, 2) : 3;
            a = BASE + 32'(bank) * 32'd8192 + 32'($urandom_range(0, 8191));
            if (r == 9) a = BASE - 32'($urandom_range(1, 4096));
            if ($urandom_range(0, 3) != 0) a = (sz == 2'd1) ? {a[31:1], 1'b0} : (sz == 2'd2) ? a : {a[31:2], 2'b00};
            rv = model(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3));
            runVec(rv, $sformatf("rnd%0d", n));
        end

`ifndef MEM_BUS_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h10012000; req_wdata = 32'hCAFEF00D;
        bank_ready = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            chk("wait.stall", 32'(stall), 32'd1);
            chk("wait.done", 32'(done), 32'd0);
        end
        bank_ready = 3'b010;
        @(posedge clk); #1;
        chk("wait.finalDone", 32'(done), 32'd1);
        chk("wait.busErr", 32'(bus_err), 32'd0);
        req_valid = 1'b0; bank_ready = '0;
        @(posedge clk); #1;
        chk("wait.doneOnce", 32'(done), 32'd0);
`else
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_zext = 1'b0; req_addr = 32'h10014000;
        bank_rdata[64 +: 32] = 32'h55555555; bank_ready = '0;
        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            chk("tmo.stall", 32'(stall), 32'd1);
            chk("tmo.early", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        chk("tmo.done", 32'(done), 32'd1);
        chk("tmo.rdata", rdata, 32'd0);
        chk("tmo.busErr", 32'(bus_err), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("tmo.doneOnce", 32'(done), 32'd0);
        chk("tmo.sticky", 32'(bus_err), 32'd1);
`endif

        // Reset during ACCESS: the access is abandoned with no completion pulse
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h10014000; req_wdata = 32'h0BADF00D;
        bank_ready = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort.en", 32'(bank_en), 32'b100);
        end
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.en0", 32'(bank_en), 32'd0);
        chk("abort.we0", 32'(bank_we), 32'd0);
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.rdata", rdata, 32'd0);
        chk("abort.busErr", 32'(bus_err), 32'd0);
        rst = 1'b0;
        bank_ready = 3'b111;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("abort.noDone", 32'(done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
